uart_param: RTL and testbench
=============================

Name: uart_param

Overview:
Parametrised full-duplex UART with an internal baud generator, 16x-oversampled receiver and transmitter, and a first-word-fall-through FIFO on each direction.
Adds features the previous UART lacks:
- configurable data width and stop length
- runtime parity
- framing, parity and overrun error detection
- input synchroniser
- a TX pop handshake that only pops when the transmitter is idle
Sits between the host bus logic and the serial pins.

Parameters:
DBIT, 8, data bits per frame (5..9)
SB_TICK, 16, oversample ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW per direction
DVSR_W, 16, width of the baud divisor

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dvsr  in  DVSR_W  baud divisor; one tick every dvsr+1 clocks
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even parity
rx  in  1  serial input (asynchronous)
tx  out  1  serial output, idle high
wr_uart  in  1  push w_data into the TX FIFO
w_data  in  DBIT  TX write data
tx_full  out  1  TX FIFO full
tx_busy  out  1  transmitter not idle
rd_uart  in  1  pop the RX FIFO head
r_data  out  DBIT  RX FIFO head (FWFT)
rx_empty  out  1  RX FIFO empty
frame_err  out  1  sticky: stop bit sampled 0
parity_err  out  1  sticky: parity mismatch
overrun_err  out  1  sticky: frame received while RX FIFO full
err_clr  in  1  clears all sticky error flags

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_full=0, rx_empty=1, r_data=0, all error flags 0. Both FSMs go to IDLE, both FIFOs empty, baud counter 0. Reset mid-frame aborts the frame immediately.
- Baud tick: counter runs 0..dvsr, tick pulses one cycle at count==dvsr, then the counter wraps. A change to dvsr takes effect at the next wrap. dvsr=0 gives a tick every clock.
- rx passes through a 2-flop synchroniser, reset value 1. All RX timing uses the synchronised signal.
- RX FSM states and transitions:
  - IDLE: on synchronised rx=0 -> START, tick count n=0.
  - START: at n==7, if rx still 0 -> DATA, otherwise -> IDLE (glitch reject, nothing written).
  - DATA: sample every 16 ticks, LSB first; after DBIT bits -> PARITY if the latched parity_en is 1, else -> STOP.
  - PARITY: sample at 16 ticks. Mismatch against (^data ^ parity_odd) sets parity_err.
  - STOP: after SB_TICK ticks, sample rx; 0 sets frame_err. Then push the byte -> IDLE.
- RX push rules:
  - Bytes with frame or parity errors are still pushed.
  - If the RX FIFO is full at push time: byte dropped, overrun_err set, FIFO contents unchanged.
- parity_en and parity_odd are latched at START entry, so a mid-frame change is ignored.
- TX FSM states and transitions:
  - IDLE: if the TX FIFO is non-empty and a tick occurs, pop the head into the shift register, latch the parity config, drive tx=0 -> START.
  - START: tx=0 for 16 ticks -> DATA.
  - DATA: shift LSB first, 16 ticks per bit -> PARITY if latched parity_en, else -> STOP.
  - PARITY: drive ^data ^ parity_odd for 16 ticks -> STOP.
  - STOP: tx=1 for SB_TICK ticks -> IDLE.
- tx_busy=1 in every TX state except IDLE. Back-to-back frames add no extra idle bit.
- FIFOs (FWFT):
  - Push when full is ignored; pop when empty is ignored and r_data holds.
  - Simultaneous push and pop when full: both occur.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo depth. Occupancy is tracked with an (FIFO_AW+1)-bit count.
  - A write is visible on r_data one cycle after the push.
- Error flags: sticky. err_clr clears them in the next cycle. If a set and err_clr occur in the same cycle, the set wins.

Decomposition:
- uart_pkg: rx/tx state enums (IDLE, START, DATA, PARITY, STOP), OVS=16 constant, START_MID=7 constant.
- One sub-module, sync_fifo: FWFT, parameters DW and AW, ports clk, rst_n, wr, rd, din, dout, full, empty. Instantiated twice.
- Baud generator, RX FSM and TX FSM are written inline.

Test Plan:
- Loopback (tx->rx), dvsr=1, parity off: write 0xA5. tx shows 0,1,0,1,0,0,1,0,1,1 at 32 clks per bit. rx_empty falls, r_data=0xA5, no error flags set.
- Parity: parity_en=1, 0xA5 (four ones). parity_odd=0 gives parity bit 0; parity_odd=1 gives bit 1. Inject a flipped parity bit -> parity_err=1, byte still readable as 0xA5.
- Framing: drive frame 0x3C with stop=0 -> frame_err=1, r_data=0x3C. err_clr pulse -> frame_err=0 next cycle.
- Overrun, FIFO_AW=4: send 17 frames 0x00..0x10 without reading -> 16 stored, overrun_err=1. Reads return 0x00..0x0F, then rx_empty=1.
- Glitch reject: rx low for 4 ticks -> RX FSM returns to IDLE, rx_empty stays 1.
- Reset mid-frame: drop rst_n during TX DATA -> tx=1 and tx_busy=0 immediately, tx_full=0, rx_empty=1. After release, a new 0x55 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding and oversampling constants for the UART RX and TX engines.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam int unsigned OVS       = 16;
   localparam int unsigned START_MID = 7;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on dout.
module sync_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr,
   input  logic          rd,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DEPTH = 2**AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign full  = (r_cnt == (AW+1)'(DEPTH));
   assign empty = (r_cnt == '0);
   assign w_pop = rd && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
   assign w_push = wr && (!full || w_pop);
   assign dout   = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= din;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART: baud generator, 16x-oversampled RX/TX engines with runtime
// parity and sticky error flags, and an FWFT FIFO in each direction.
module uart_param
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned DVSR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              rx,
   output logic              tx,
   input  logic              wr_uart,
   input  logic [DBIT-1:0]   w_data,
   output logic              tx_full,
   output logic              tx_busy,
   input  logic              rd_uart,
   output logic [DBIT-1:0]   r_data,
   output logic              rx_empty,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun_err,
   input  logic              err_clr
);

   localparam int unsigned CW = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
   localparam int unsigned BW = $clog2(DBIT);

   // Baud generator: limit reloads only at wrap so a dvsr change never truncates a period.
   logic [DVSR_W-1:0] r_bcnt;
   logic [DVSR_W-1:0] r_blim;
   logic              w_tick;

   assign w_tick = (r_bcnt == r_blim);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt <= '0;
         r_blim <= '0;
      end else if (w_tick) begin
         r_bcnt <= '0;
         r_blim <= dvsr;
      end else begin
         r_bcnt <= r_bcnt + DVSR_W'(1);
      end
   end

   logic r_rx_meta;
   logic r_rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   uart_state_e     r_rx_st;
   logic [CW-1:0]   r_rx_n;
   logic [BW-1:0]   r_rx_b;
   logic [DBIT-1:0] r_rx_sh;
   logic            r_rx_pen;
   logic            r_rx_podd;
   logic            w_rx_push;
   logic            w_rx_full;
   logic            w_par_bad;
   logic            w_frm_bad;
   logic            w_ovr;

   assign w_rx_push = (r_rx_st == STOP) && w_tick && (r_rx_n == CW'(SB_TICK - 1));
   assign w_par_bad = (r_rx_st == PARITY) && w_tick && (r_rx_n == CW'(OVS - 1)) &&
                      (r_rx_sync != (^r_rx_sh ^ r_rx_podd));
   assign w_frm_bad = w_rx_push && !r_rx_sync;
   assign w_ovr     = w_rx_push && w_rx_full && !rd_uart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_st   <= IDLE;
         r_rx_n    <= '0;
         r_rx_b    <= '0;
         r_rx_sh   <= '0;
         r_rx_pen  <= 1'b0;
         r_rx_podd <= 1'b0;
      end else begin
         case (r_rx_st)
            IDLE: begin
               if (!r_rx_sync) begin
                  r_rx_st   <= START;
                  r_rx_n    <= '0;
                  r_rx_pen  <= parity_en;
                  r_rx_podd <= parity_odd;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_rx_n == CW'(START_MID)) begin
                     r_rx_n <= '0;
                     r_rx_b <= '0;
                     r_rx_st <= r_rx_sync ? IDLE : DATA;
                  end else begin
                     r_rx_n <= r_rx_n + CW'(1);
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_rx_n == CW'(OVS - 1)) begin
                     r_rx_n  <= '0;
                     r_rx_sh <= {r_rx_sync, r_rx_sh[DBIT-1:1]};
                     if (r_rx_b == BW'(DBIT - 1)) begin
                        r_rx_st <= r_rx_pen ? PARITY : STOP;
                     end else begin
                        r_rx_b <= r_rx_b + BW'(1);
                     end
                  end else begin
                     r_rx_n <= r_rx_n + CW'(1);
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  if (r_rx_n == CW'(OVS - 1)) begin
                     r_rx_n  <= '0;
                     r_rx_st <= STOP;
                  end else begin
                     r_rx_n <= r_rx_n + CW'(1);
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_rx_n == CW'(SB_TICK - 1)) begin
                     r_rx_n  <= '0;
                     r_rx_st <= IDLE;
                  end else begin
                     r_rx_n <= r_rx_n + CW'(1);
                  end
               end
            end
            default: r_rx_st <= IDLE;
         endcase
      end
   end

   logic r_frame_err;
   logic r_parity_err;
   logic r_overrun_err;

   // A new error event takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_err   <= 1'b0;
         r_parity_err  <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         if (w_frm_bad)    r_frame_err   <= 1'b1;
         else if (err_clr) r_frame_err   <= 1'b0;
         if (w_par_bad)    r_parity_err  <= 1'b1;
         else if (err_clr) r_parity_err  <= 1'b0;
         if (w_ovr)        r_overrun_err <= 1'b1;
         else if (err_clr) r_overrun_err <= 1'b0;
      end
   end

   assign frame_err   = r_frame_err;
   assign parity_err  = r_parity_err;
   assign overrun_err = r_overrun_err;

   uart_state_e     r_tx_st;
   logic [CW-1:0]   r_tx_n;
   logic [BW-1:0]   r_tx_b;
   logic [DBIT-1:0] r_tx_sh;
   logic            r_tx_par;
   logic            r_tx_pen;
   logic            r_tx;
   logic            w_tx_empty;
   logic [DBIT-1:0] w_tx_dout;
   logic            w_tx_load;

   // Reloading straight from the last stop tick keeps back-to-back frames gap-free.
   assign w_tx_load = w_tick && !w_tx_empty &&
                      ((r_tx_st == IDLE) ||
                       ((r_tx_st == STOP) && (r_tx_n == CW'(SB_TICK - 1))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_st  <= IDLE;
         r_tx_n   <= '0;
         r_tx_b   <= '0;
         r_tx_sh  <= '0;
         r_tx_par <= 1'b0;
         r_tx_pen <= 1'b0;
         r_tx     <= 1'b1;
      end else if (w_tx_load) begin
         r_tx_st  <= START;
         r_tx_n   <= '0;
         r_tx_sh  <= w_tx_dout;
         r_tx_par <= ^w_tx_dout ^ parity_odd;
         r_tx_pen <= parity_en;
         r_tx     <= 1'b0;
      end else begin
         case (r_tx_st)
            IDLE: r_tx <= 1'b1;
            START: begin
               if (w_tick) begin
                  if (r_tx_n == CW'(OVS - 1)) begin
                     r_tx_n  <= '0;
                     r_tx_b  <= '0;
                     r_tx_st <= DATA;
                     r_tx    <= r_tx_sh[0];
                  end else begin
                     r_tx_n <= r_tx_n + CW'(1);
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_tx_n == CW'(OVS - 1)) begin
                     r_tx_n <= '0;
                     if (r_tx_b == BW'(DBIT - 1)) begin
                        r_tx_st <= r_tx_pen ? PARITY : STOP;
                        r_tx    <= r_tx_pen ? r_tx_par : 1'b1;
                     end else begin
                        r_tx_b  <= r_tx_b + BW'(1);
                        r_tx_sh <= {1'b0, r_tx_sh[DBIT-1:1]};
                        r_tx    <= r_tx_sh[1];
                     end
                  end else begin
                     r_tx_n <= r_tx_n + CW'(1);
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  if (r_tx_n == CW'(OVS - 1)) begin
                     r_tx_n  <= '0;
                     r_tx_st <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_tx_n <= r_tx_n + CW'(1);
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_tx_n == CW'(SB_TICK - 1)) begin
                     r_tx_n  <= '0;
                     r_tx_st <= IDLE;
                  end else begin
                     r_tx_n <= r_tx_n + CW'(1);
                  end
               end
            end
            default: r_tx_st <= IDLE;
         endcase
      end
   end

   assign tx      = r_tx;
   assign tx_busy = (r_tx_st != IDLE);

   sync_fifo #(
      .DW (DBIT),
      .AW (FIFO_AW)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr_uart),
      .rd    (w_tx_load),
      .din   (w_data),
      .dout  (w_tx_dout),
      .full  (tx_full),
      .empty (w_tx_empty)
   );

   sync_fifo #(
      .DW (DBIT),
      .AW (FIFO_AW)
   ) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (w_rx_push),
      .rd    (rd_uart),
      .din   (r_rx_sh),
      .dout  (r_data),
      .full  (w_rx_full),
      .empty (rx_empty)
   );

endmodule

// File: tb/tb_uart_param.sv
// Randomized loopback and directed-line bench for uart_param against a frame-level model.
module tb_uart_param;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int FIFO_AW = 4;
   localparam int DVSR_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DVSR_W-1:0] dvsr;
   logic              parity_en;
   logic              parity_odd;
   logic              rx;
   logic              tx;
   logic              wr_uart;
   logic [DBIT-1:0]   w_data;
   logic              tx_full;
   logic              tx_busy;
   logic              rd_uart;
   logic [DBIT-1:0]   r_data;
   logic              rx_empty;
   logic              frame_err;
   logic              parity_err;
   logic              overrun_err;
   logic              err_clr;
   logic              tb_rx;
   logic              loop;

   int checks   = 0;
   int failures = 0;
   int P        = 32;
   logic [7:0] tx_list[$];

   always #5 clk = ~clk;
   assign rx = loop ? tx : tb_rx;

   uart_param #(
      .DBIT    (DBIT),
      .SB_TICK (SB_TICK),
      .FIFO_AW (FIFO_AW),
      .DVSR_W  (DVSR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dvsr        (dvsr),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .rx          (rx),
      .tx          (tx),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .tx_full     (tx_full),
      .tx_busy     (tx_busy),
      .rd_uart     (rd_uart),
      .r_data      (r_data),
      .rx_empty    (rx_empty),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun_err (overrun_err),
      .err_clr     (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic par_of(input logic [7:0] d, input logic odd);
      return (($countones(d) % 2) == 1) ^ odd;
   endfunction

   task automatic chk_errs(input string tag, input logic fe, input logic pe, input logic oe);
      chk({tag, "_frame_err"},   32'(frame_err),   32'(fe));
      chk({tag, "_parity_err"},  32'(parity_err),  32'(pe));
      chk({tag, "_overrun_err"}, 32'(overrun_err), 32'(oe));
   endtask

   // Expected line: start 0, data LSB first, optional parity, stop 1, frames contiguous.
   task automatic mon_tx(input string tag);
      logic exp_bits[$];
      int   cnt = 0;
      foreach (tx_list[k]) begin
         exp_bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) exp_bits.push_back(tx_list[k][i]);
         if (parity_en) exp_bits.push_back(par_of(tx_list[k], parity_odd));
         for (int s = 0; s < SB_TICK / 16; s++) exp_bits.push_back(1'b1);
      end
      while (tx !== 1'b0 && cnt < 4000) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_start"}, 32'(tx), 32'd0);
      repeat (P / 2) @(negedge clk);
      for (int j = 0; j < exp_bits.size(); j++) begin
         chk({tag, "_bit"}, 32'(tx), 32'(exp_bits[j]));
         if (j < exp_bits.size() - 1) repeat (P) @(negedge clk);
      end
   endtask

   task automatic read_check(input string tag, input logic [7:0] exp);
      int cnt = 0;
      while (rx_empty && cnt < 8000) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_avail"}, 32'(rx_empty), 32'd0);
      chk(tag, 32'(r_data), 32'(exp));
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
   endtask

   task automatic send_batch(input string tag);
      loop = 1'b1;
      P = 16 * (int'(dvsr) + 1);
      repeat (4 * P) @(negedge clk);
      fork
         mon_tx(tag);
         begin
            foreach (tx_list[k]) begin
               wr_uart = 1'b1;
               w_data  = tx_list[k];
               @(negedge clk);
            end
            wr_uart = 1'b0;
         end
      join
      repeat (P) @(negedge clk);
      chk({tag, "_busy"}, 32'(tx_busy), 32'd0);
      foreach (tx_list[k]) read_check({tag, "_rx"}, tx_list[k]);
      chk({tag, "_drained"}, 32'(rx_empty), 32'd1);
      chk_errs(tag, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic flip, input logic stop_bad);
      tb_rx = 1'b0;
      repeat (P) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         tb_rx = d[i];
         repeat (P) @(negedge clk);
      end
      if (parity_en) begin
         tb_rx = par_of(d, parity_odd) ^ flip;
         repeat (P) @(negedge clk);
      end
      if (stop_bad) begin
         tb_rx = 1'b0;
         repeat (P * 3 / 4) @(negedge clk);
         tb_rx = 1'b1;
         repeat (2 * P) @(negedge clk);
      end else begin
         tb_rx = 1'b1;
         repeat (P) @(negedge clk);
      end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst_n = 1'b0; dvsr = 16'd1; parity_en = 1'b0; parity_odd = 1'b0;
      wr_uart = 1'b0; w_data = '0; rd_uart = 1'b0; err_clr = 1'b0;
      tb_rx = 1'b1; loop = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_full", 32'(tx_full), 32'd0);
      chk("rst_empty", 32'(rx_empty), 32'd1);
      chk("rst_rdata", 32'(r_data), 32'd0);
      chk_errs("rst", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      tx_list = '{8'hA5};
      send_batch("loop_a5");
      parity_en = 1'b1; parity_odd = 1'b0;
      send_batch("par_even");
      parity_odd = 1'b1;
      send_batch("par_odd");

      for (int b = 0; b < 4; b++) begin
         dvsr       = 16'($urandom_range(0, 3));
         parity_en  = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         tx_list.delete();
         for (int k = 0; k < int'($urandom_range(1, 4)); k++) tx_list.push_back(8'($urandom_range(0, 255)));
         send_batch("rand");
      end

      dvsr = 16'd1; P = 32; loop = 1'b0;
      repeat (8) @(negedge clk);
      parity_en = 1'b1; parity_odd = 1'b0;
      send_rx(8'hA5, 1'b1, 1'b0);
      read_check("par_inject", 8'hA5);
      chk_errs("par_inject", 1'b0, 1'b1, 1'b0);
      pulse_clr();
      chk("par_clr", 32'(parity_err), 32'd0);

      parity_en = 1'b0;
      send_rx(8'h3C, 1'b0, 1'b1);
      read_check("frame", 8'h3C);
      chk_errs("frame", 1'b1, 1'b0, 1'b0);
      pulse_clr();
      chk("frame_clr", 32'(frame_err), 32'd0);
      repeat (4 * P) @(negedge clk);
      chk("frame_no_ghost", 32'(rx_empty), 32'd1);

      tb_rx = 1'b0;
      repeat (8) @(negedge clk);
      tb_rx = 1'b1;
      repeat (3 * P) @(negedge clk);
      chk("glitch_empty", 32'(rx_empty), 32'd1);
      chk_errs("glitch", 1'b0, 1'b0, 1'b0);

      for (int k = 0; k <= 16; k++) send_rx(8'(k), 1'b0, 1'b0);
      chk("ovr_flag", 32'(overrun_err), 32'd1);
      for (int k = 0; k < 16; k++) read_check("ovr_rd", 8'(k));
      chk("ovr_drained", 32'(rx_empty), 32'd1);
      pulse_clr();
      chk_errs("ovr_clr", 1'b0, 1'b0, 1'b0);

      loop = 1'b1;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 17; k++) begin
         wr_uart = 1'b1;
         w_data  = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      wr_uart = 1'b0;
      chk("mid_full", 32'(tx_full), 32'd1);
      repeat (3 * P) @(negedge clk);
      chk("mid_busy", 32'(tx_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(tx_busy), 32'd0);
      chk("mid_rst_full", 32'(tx_full), 32'd0);
      chk("mid_rst_empty", 32'(rx_empty), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_list = '{8'h55};
      send_batch("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
